// File: rtl/instr_mem_pkg.sv
// instr_mem_pkg
//   Shared types and helpers for the loadable instruction memory.
//   - state_t : controller state (LOAD while the program streams in, RUN when fetches are served)
//   - clog2   : constant ceiling-log2 used to size the word index
//   - NOP     : word returned for fetches of locations never loaded
package instr_mem_pkg;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int unsigned NOP = 0;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/imem_sram_1r1w.sv
// imem_sram_1r1w
//   DEPTH x WIDTH storage array, one synchronous write port and one
//   registered read port. No reset: contents survive Reset by design.
//   Ports:
//     i_clk   - rising-edge clock
//     i_we    - write enable
//     i_waddr - write word index
//     i_wdata - write data
//     i_re    - read enable; o_rdata holds its value when low
//     i_raddr - read word index
//     o_rdata - read data, valid the cycle after i_re
module imem_sram_1r1w #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 128,
    parameter int unsigned AW    = 7
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/instr_mem_loadable.sv
// instr_mem_loadable
//   Instruction memory that is filled through a streaming load port after
//   reset, then serves fetches with one cycle of latency.
//   Ports:
//     Clk, Reset (async, active low)
//     LoadValid/LoadData/LoadLast - program word stream, LoadLast ends loading
//     Ready        - in RUN, fetches accepted
//     LoadOverflow - sticky, a word arrived with the array already full
//     WordCount    - number of words stored (saturates at DEPTH)
//     FetchReq/Address - fetch request with byte address
//     InstrValid/Instruction/Fault - fetch response, one cycle after request
module instr_mem_loadable
    import instr_mem_pkg::*;
#(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned DEPTH        = 128,
    parameter bit          STRICT_ALIGN = 1'b0
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    LoadValid,
    input  logic [WIDTH-1:0]        LoadData,
    input  logic                    LoadLast,
    output logic                    Ready,
    output logic                    LoadOverflow,
    output logic [clog2(DEPTH):0]   WordCount,
    input  logic                    FetchReq,
    input  logic [31:0]             Address,
    output logic                    InstrValid,
    output logic [WIDTH-1:0]        Instruction,
    output logic                    Fault
);

    localparam int unsigned AW      = clog2(DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    state_t           r_state;
    logic [AW:0]      r_ptr;
    logic             r_overflow;
    logic             r_valid;
    logic             r_fault;
    logic             r_hit;     // response should carry the array word

    logic             w_full;
    logic             w_we;
    logic             w_accept;
    logic [AW-1:0]    w_idx;
    logic             w_fault;
    logic             w_loaded;
    logic [WIDTH-1:0] w_rdata;

    assign w_full   = (r_ptr == DEPTH_W);
    assign w_we     = (r_state == LOAD) && LoadValid && !w_full;
    assign w_accept = (r_state == RUN) && FetchReq;
    assign w_idx    = Address[AW+1:2];
    assign w_fault  = (Address[31:AW+2] != '0) ||
                      (STRICT_ALIGN && (Address[1:0] != 2'b00));
    // Locations at or beyond the count may hold stale data from before
    // the last reset; they must read back as NOP.
    assign w_loaded = ({1'b0, w_idx} < r_ptr);

    imem_sram_1r1w #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_sram (
        .i_clk   (Clk),
        .i_we    (w_we),
        .i_waddr (r_ptr[AW-1:0]),
        .i_wdata (LoadData),
        .i_re    (w_accept),
        .i_raddr (w_idx),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state    <= LOAD;
            r_ptr      <= '0;
            r_overflow <= 1'b0;
            r_valid    <= 1'b0;
            r_fault    <= 1'b0;
            r_hit      <= 1'b0;
        end else begin
            case (r_state)
                LOAD: begin
                    r_valid <= 1'b0;
                    if (LoadValid) begin
                        if (w_full) r_overflow <= 1'b1;
                        else        r_ptr      <= r_ptr + 1'b1;
                        if (LoadLast) r_state <= RUN;
                    end
                end
                RUN: begin
                    r_valid <= FetchReq;
                    if (FetchReq) begin
                        r_fault <= w_fault;
                        r_hit   <= !w_fault && w_loaded;
                    end
                end
                default: r_state <= LOAD;
            endcase
        end
    end

    // The array holds its read data between requests, so gating it with the
    // registered hit flag keeps Instruction stable when no fetch is issued.
    assign Instruction  = r_hit ? w_rdata : WIDTH'(NOP);
    assign Ready        = (r_state == RUN);
    assign LoadOverflow = r_overflow;
    assign WordCount    = r_ptr;
    assign InstrValid   = r_valid;
    assign Fault        = r_fault;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// tb_instr_mem_loadable
//   Drives two instances (STRICT_ALIGN = 0 and 1) with identical stimulus and
//   compares every cycle against a behavioural model of the memory.
module tb_instr_mem_loadable;

    localparam int unsigned DEPTH = 128;
    localparam int unsigned AWM   = 7;

    logic        Clk;
    logic        Reset;
    logic        LoadValid;
    logic [31:0] LoadData;
    logic        LoadLast;
    logic        FetchReq;
    logic [31:0] Address;

    logic        rdy   [2];
    logic        ovf   [2];
    logic [AWM:0] wc   [2];
    logic        vld   [2];
    logic [31:0] instr [2];
    logic        flt   [2];

    int n_cmp;
    int n_err;

    // behavioural model
    logic [31:0] m_mem [DEPTH];
    int          m_count;
    bit          m_run;
    bit          m_ovf;
    bit          m_valid [2];
    logic [31:0] m_instr [2];
    bit          m_fault [2];

    instr_mem_loadable #(.WIDTH(32), .DEPTH(DEPTH), .STRICT_ALIGN(1'b0)) u_dut0 (
        .Clk(Clk), .Reset(Reset), .LoadValid(LoadValid), .LoadData(LoadData),
        .LoadLast(LoadLast), .Ready(rdy[0]), .LoadOverflow(ovf[0]), .WordCount(wc[0]),
        .FetchReq(FetchReq), .Address(Address), .InstrValid(vld[0]),
        .Instruction(instr[0]), .Fault(flt[0])
    );

    instr_mem_loadable #(.WIDTH(32), .DEPTH(DEPTH), .STRICT_ALIGN(1'b1)) u_dut1 (
        .Clk(Clk), .Reset(Reset), .LoadValid(LoadValid), .LoadData(LoadData),
        .LoadLast(LoadLast), .Ready(rdy[1]), .LoadOverflow(ovf[1]), .WordCount(wc[1]),
        .FetchReq(FetchReq), .Address(Address), .InstrValid(vld[1]),
        .Instruction(instr[1]), .Fault(flt[1])
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        for (int s = 0; s < 2; s++) begin
            check_val($sformatf("ready%0d", s), 64'(rdy[s]), 64'(m_run));
            check_val($sformatf("wordcount%0d", s), 64'(wc[s]), 64'(m_count));
            check_val($sformatf("overflow%0d", s), 64'(ovf[s]), 64'(m_ovf));
            check_val($sformatf("valid%0d", s), 64'(vld[s]), 64'(m_valid[s]));
            check_val($sformatf("instr%0d", s), 64'(instr[s]), 64'(m_instr[s]));
            if (m_valid[s])
                check_val($sformatf("fault%0d", s), 64'(flt[s]), 64'(m_fault[s]));
        end
    endtask

    // Called just after a falling edge; returns just after the next one.
    task automatic step(input logic lv, input logic [31:0] ld, input logic ll,
                        input logic fr, input logic [31:0] addr);
        int idx;
        bit f;
        LoadValid = lv;
        LoadData  = ld;
        LoadLast  = ll;
        FetchReq  = fr;
        Address   = addr;
        idx = int'((addr >> 2) % DEPTH);
        for (int s = 0; s < 2; s++) begin
            if (m_run && fr) begin
                f = (addr >= DEPTH * 4) || (s == 1 && (addr % 4) != 0);
                m_valid[s] = 1'b1;
                m_fault[s] = f;
                m_instr[s] = f ? 32'h0 : ((idx < m_count) ? m_mem[idx] : 32'h0);
            end else begin
                m_valid[s] = 1'b0;
            end
        end
        if (!m_run && lv) begin
            if (m_count < DEPTH) begin
                m_mem[m_count] = ld;
                m_count++;
            end else begin
                m_ovf = 1'b1;
            end
            if (ll) m_run = 1'b1;
        end
        @(posedge Clk);
        @(negedge Clk);
        check_outputs();
    endtask

    task automatic fetch(input logic [31:0] addr);
        step(1'b0, 32'h0, 1'b0, 1'b1, addr);
    endtask

    task automatic apply_reset();
        #2;
        Reset     = 1'b0;
        LoadValid = 1'b0;
        LoadData  = '0;
        LoadLast  = 1'b0;
        FetchReq  = 1'b0;
        Address   = '0;
        m_count = 0;
        m_run   = 1'b0;
        m_ovf   = 1'b0;
        for (int s = 0; s < 2; s++) begin
            m_valid[s] = 1'b0;
            m_instr[s] = 32'h0;
            m_fault[s] = 1'b0;
        end
        #1;
        check_outputs();
        for (int s = 0; s < 2; s++)
            check_val($sformatf("rst_fault%0d", s), 64'(flt[s]), 64'(0));
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
    endtask

    function automatic logic [31:0] rand_addr();
        int lim;
        lim = (m_count > 0) ? m_count : 1;
        case ($urandom_range(0, 4))
            0:       return 32'($urandom_range(0, lim - 1)) << 2;
            1:       return 32'($urandom_range(0, DEPTH - 1)) << 2;
            2:       return (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
            3:       return $urandom;
            default: return 32'(DEPTH * 4) + 32'($urandom_range(0, 64));
        endcase
    endfunction

    initial begin
        logic [31:0] w127;
        int n;
        int loaded;
        bit lv;
        bit ll;
        n_cmp = 0;
        n_err = 0;
        Reset     = 1'b1;
        LoadValid = 1'b0;
        LoadData  = '0;
        LoadLast  = 1'b0;
        FetchReq  = 1'b0;
        Address   = '0;
        @(negedge Clk);
        apply_reset();

        // Three-word program; FetchReq held high while loading must be ignored.
        step(1'b1, 32'h34070000, 1'b0, 1'b1, 32'h0);
        step(1'b1, 32'h8ce70000, 1'b0, 1'b1, 32'h4);
        step(1'b1, 32'h34040004, 1'b1, 1'b1, 32'h8);
        check_val("plan_ready", 64'(rdy[0]), 64'(1));
        check_val("plan_wc", 64'(wc[0]), 64'(3));
        check_val("plan_noresp_lastcycle", 64'(vld[0]), 64'(0));
        fetch(32'h8);
        check_val("plan_f8", 64'(instr[0]), 64'h34040004);
        fetch(32'h0);
        check_val("plan_f0", 64'(instr[0]), 64'h34070000);
        fetch(32'h4);
        check_val("plan_f4", 64'(instr[0]), 64'h8ce70000);
        fetch(32'hC);
        check_val("plan_fC", 64'(instr[0]), 64'h0);
        check_val("plan_fC_fault", 64'(flt[0]), 64'(0));
        fetch(32'h200);
        check_val("plan_f200_fault", 64'(flt[0]), 64'(1));
        check_val("plan_f200_instr", 64'(instr[0]), 64'h0);
        fetch(32'h5);
        check_val("plan_f5_loose", 64'(instr[0]), 64'h8ce70000);
        check_val("plan_f5_strict", 64'(flt[1]), 64'(1));
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);   // idle: Instruction holds
        // load port ignored in RUN
        step(1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h0);

        // Overflow: DEPTH + 2 words, then a final word with LoadLast.
        fetch(32'h0);
        apply_reset();   // also abandons the just-issued fetch
        w127 = 32'h0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            if (i == DEPTH - 1) w127 = $urandom;
            step(1'b1, (i == DEPTH - 1) ? w127 : $urandom, 1'b0, 1'b0, 32'h0);
        end
        step(1'b1, 32'h12345678, 1'b1, 1'b0, 32'h0);
        check_val("ovf_flag", 64'(ovf[0]), 64'(1));
        check_val("ovf_wc", 64'(wc[0]), 64'(DEPTH));
        fetch(32'(DEPTH * 4 - 4));
        check_val("ovf_last_word", 64'(instr[0]), 64'(w127));

        // Reset in mid-load, then a one-word program.
        apply_reset();
        step(1'b1, 32'h11111111, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'h22222222, 1'b0, 1'b0, 32'h0);
        apply_reset();
        step(1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 32'h0);
        check_val("rst_wc", 64'(wc[0]), 64'(1));
        fetch(32'h4);
        check_val("rst_f4", 64'(instr[0]), 64'h0);
        fetch(32'h0);
        check_val("rst_f0", 64'(instr[0]), 64'hDEADBEEF);

        // Randomized rounds
        for (int r = 0; r < 6; r++) begin
            apply_reset();
            n = $urandom_range(1, DEPTH + 4);
            loaded = 0;
            while (loaded < n) begin
                lv = ($urandom_range(0, 3) != 0);
                ll = lv ? (loaded == n - 1) : 1'($urandom_range(0, 1));
                step(lv, $urandom, ll, 1'($urandom_range(0, 1)), rand_addr());
                if (lv) loaded++;
            end
            for (int c = 0; c < 150; c++)
                step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) != 0), rand_addr());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
